// File: rtl/imm_extend_pipe.sv
// Immediate-extension stage: widens an IN_W-bit field to OUT_W bits in one of four modes
// and buffers the results in a DEPTH-entry valid/ready FIFO with a saturating push counter.
module imm_extend_pipe #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] xfer_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    logic [OUT_W-1:0] data_q [DEPTH];
    logic             err_q  [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] ext_data;
    logic             ext_err;
    logic             push, pop;

    always_comb begin
        ext_data = '0;
        ext_err  = 1'b0;
        case (in_mode)
            2'b00:   ext_data = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
            2'b01:   ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
            2'b10:   ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
            default: ext_err  = 1'b1;
        endcase
    end

    // in_ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? data_q[rd_q] : '0;
    assign out_err   = out_valid ? err_q[rd_q] : 1'b0;
    assign xfer_cnt  = cnt_q;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        if (pop) rd_d = (rd_q == LAST_P) ? '0 : rd_q + PTR_W'(1);
        if (push) begin
            wr_d = (wr_q == LAST_P) ? '0 : wr_q + PTR_W'(1);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: entries are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            data_q[wr_q] <= ext_data;
            err_q[wr_q]  <= ext_err;
        end
    end
endmodule
